// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: clocking constants,
// scheduler state encoding and the counter width helper.
package uart_pkg;

    localparam int SYS_CLK_FREQ = 125000000;
    localparam int BAUD_RATE    = 115200;
    localparam int BAUD_LENGTH  = SYS_CLK_FREQ / BAUD_RATE;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } sched_state_e;

    // Wide enough to hold the larger of the two terminal counts without overflow.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or above ptr,
// wrapping modulo N. Correct for non-power-of-two N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic          found;
    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one byte-wide UART transmitter among NUM_REQ requesters, granting
// whole packets round-robin with an idle gap and a stall timeout.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = BAUD_LENGTH,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                        sysclk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);
    localparam sched_state_e  POST_PKT = (GAP_CYCLES == 0) ? IDLE : GAP;

    sched_state_e   state_q, state_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]  arb_idx;
    logic [IW-1:0]  next_ptr;
    logic           accept;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign next_ptr = (grant_q == LAST_ID) ? '0 : grant_q + IW'(1);
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // One counter serves both the stall timeout in XFER and the gap in GAP.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        timeout_err = 1'b0;
        accept      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|arb_grant) begin
                    grant_d = arb_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                tx_valid           = req_valid[grant_q];
                tx_data            = req_data[BYTE_W*int'(grant_q) +: BYTE_W];
                req_ready[grant_q] = tx_ready;
                accept             = tx_valid && tx_ready;
                if (accept) begin
                    cnt_d = '0;
                    if (req_last[grant_q]) begin
                        rr_ptr_d = next_ptr;
                        state_d  = POST_PKT;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == TO_LAST) begin
                        timeout_err = 1'b1;
                        rr_ptr_d    = next_ptr;
                        cnt_d       = '0;
                        state_d     = POST_PKT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing leaves the block while reset is held, whatever state it was in.
        if (rst) begin
            req_ready   = '0;
            tx_valid    = 1'b0;
            timeout_err = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed vector table, hand-written
// corner sequences and randomized packet traffic against a packet-level model.
module tb_uart_tx_scheduler;

    localparam int GAP_A = 4;
    localparam int TO_A  = 16;
    localparam int NUM_VEC = 19;

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        rdy;
        logic        eValid;
        logic [7:0]  eData;
        logic [3:0]  eReady;
        logic        eBusy;
        logic [1:0]  eGrant;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  reqValid, reqLast, reqReady;
    logic [31:0] reqData;
    logic        txReady, txValid, busy, timeoutErr;
    logic [7:0]  txData;
    logic [1:0]  grantId;

    logic        bRst;
    logic [3:0]  bReqValid, bReqLast, bReqReady;
    logic [31:0] bReqData;
    logic        bTxReady, bTxValid, bBusy, bTimeoutErr;
    logic [7:0]  bTxData;
    logic [1:0]  bGrantId;

    int errors = 0;
    int checks = 0;

    vec_t vecs [NUM_VEC];

    logic [7:0] memData [4][16];
    int         memCnt [4];
    int         memPos [4];
    int         pkLen [4][4];
    int         pkN [4];
    logic [7:0] expData [64];
    logic       expLast [64];
    int         expN;

    uart_tx_scheduler #(
        .NUM_REQ(4), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A)
    ) dut (
        .sysclk(clk), .rst(rst), .req_valid(reqValid), .req_data(reqData),
        .req_last(reqLast), .req_ready(reqReady), .tx_data(txData),
        .tx_valid(txValid), .tx_ready(txReady), .grant_id(grantId),
        .busy(busy), .timeout_err(timeoutErr)
    );

    uart_tx_scheduler #(
        .NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO_A)
    ) dutNoGap (
        .sysclk(clk), .rst(bRst), .req_valid(bReqValid), .req_data(bReqData),
        .req_last(bReqLast), .req_ready(bReqReady), .tx_data(bTxData),
        .tx_valid(bTxValid), .tx_ready(bTxReady), .grant_id(bGrantId),
        .busy(bBusy), .timeout_err(bTimeoutErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive the main DUT at the falling edge, then settle before sampling.
    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic r);
        @(negedge clk);
        reqValid = v;
        reqData  = d;
        reqLast  = l;
        txReady  = r;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        reqValid = '0; reqData = '0; reqLast = '0; txReady = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nSrv, got, pulses, firstK, doneGrant, seen, lowRun, lastEnd, prevLast;
        int idx0, idx1, nAcc, busyAt3, ptr, win, remaining;
        int srvId [5];
        int srvByte [5];
        int accCyc [4];
        int accByte [4];
        int nextPk [4];
        int modelPos [4];
        logic [1:0]  g;
        logic [7:0]  dat;
        logic [3:0]  v, l;
        logic [31:0] d;
        logic        rdy;

        vecs[0]  = '{4'b0001, 32'h00000041, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 32'h00000041, 4'b0000, 1'b1, 1'b1, 8'h41, 4'b0001, 1'b1, 2'd0};
        vecs[2]  = '{4'b0001, 32'h00000042, 4'b0000, 1'b1, 1'b1, 8'h42, 4'b0001, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 32'h00000043, 4'b0001, 1'b1, 1'b1, 8'h43, 4'b0001, 1'b1, 2'd0};
        for (int i = 4; i < 8; i++) begin
            vecs[i] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd0};
        end
        vecs[8]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        vecs[9]  = '{4'b0100, 32'h00A00000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0};
        vecs[10] = '{4'b1111, 32'h33A01100, 4'b0000, 1'b1, 1'b1, 8'hA0, 4'b0100, 1'b1, 2'd2};
        vecs[11] = '{4'b1111, 32'h33A11100, 4'b0000, 1'b0, 1'b1, 8'hA1, 4'b0000, 1'b1, 2'd2};
        vecs[12] = '{4'b1111, 32'h33A11100, 4'b0000, 1'b0, 1'b1, 8'hA1, 4'b0000, 1'b1, 2'd2};
        vecs[13] = '{4'b1111, 32'h33A11100, 4'b0100, 1'b1, 1'b1, 8'hA1, 4'b0100, 1'b1, 2'd2};
        for (int i = 14; i < 18; i++) begin
            vecs[i] = '{4'b1011, 32'h33001100, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1, 2'd2};
        end
        vecs[18] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2};

        rst = 1'b1; reqValid = 4'b1111; reqData = 32'h11223344; reqLast = 4'b1111; txReady = 1'b1;
        bRst = 1'b1; bReqValid = '0; bReqData = '0; bReqLast = '0; bTxReady = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_tx_valid", 32'(txValid), 32'd0);
        checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_grant", 32'(grantId), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeoutErr), 32'd0);
        rst = 1'b0; reqValid = '0; reqLast = '0;
        bRst = 1'b0;

        for (int i = 0; i < NUM_VEC; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_tx_valid", i), 32'(txValid), 32'(vecs[i].eValid));
            checkOutput($sformatf("vec%0d_req_ready", i), 32'(reqReady), 32'(vecs[i].eReady));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].eBusy));
            checkOutput($sformatf("vec%0d_timeout_err", i), 32'(timeoutErr), 32'd0);
            if (vecs[i].eValid) begin
                checkOutput($sformatf("vec%0d_tx_data", i), 32'(txData), 32'(vecs[i].eData));
            end
            if (vecs[i].eBusy) begin
                checkOutput($sformatf("vec%0d_grant", i), 32'(grantId), 32'(vecs[i].eGrant));
            end
        end

        // All four requesters hold one-byte packets: served strictly in rotation.
        resetDut();
        nSrv = 0;
        for (int i = 0; i < 5; i++) begin srvId[i] = -1; srvByte[i] = -1; end
        for (int c = 0; c < 60 && nSrv < 5; c++) begin
            applyStimulus(4'b1111, 32'h13121110, 4'b1111, 1'b1);
            if (txValid && txReady) begin
                srvId[nSrv]   = int'(grantId);
                srvByte[nSrv] = int'(txData);
                nSrv++;
            end
        end
        checkOutput("rr_served_count", 32'(nSrv), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rr_grant%0d", i), 32'(srvId[i]), 32'(i % 4));
            checkOutput($sformatf("rr_byte%0d", i), 32'(srvByte[i]), 32'(8'h10 + i % 4));
        end

        // Requester 1 stalls mid-packet; grant is revoked and 2 wins next.
        resetDut();
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            applyStimulus(4'b0010, 32'h00005100, 4'b0000, 1'b1);
            if (txValid && txReady) got = 1;
        end
        checkOutput("to_first_accept", 32'(got), 32'd1);
        pulses = 0; firstK = -1; doneGrant = 0; g = '0; dat = '0;
        for (int k = 1; k <= 40 && doneGrant == 0; k++) begin
            if (pulses == 0) applyStimulus(4'b0100, 32'h00620000, 4'b0100, 1'b1);
            else             applyStimulus(4'b0110, 32'h00625200, 4'b0110, 1'b1);
            if (timeoutErr) begin
                pulses++;
                if (firstK < 0) firstK = k;
            end
            if (pulses > 0 && txValid && txReady) begin
                doneGrant = 1;
                g = grantId;
                dat = txData;
            end
        end
        checkOutput("to_pulse_delay", 32'(firstK), 32'(TO_A));
        checkOutput("to_pulse_count", 32'(pulses), 32'd1);
        checkOutput("to_regrant_seen", 32'(doneGrant), 32'd1);
        checkOutput("to_regrant_id", 32'(g), 32'd2);
        checkOutput("to_regrant_byte", 32'(dat), 32'h62);

        // One-cycle reset in the middle of a stalled XFER.
        resetDut();
        applyStimulus(4'b0001, 32'h00000041, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 32'h00000041, 4'b0000, 1'b0);
        checkOutput("rstx_pre_tx_valid", 32'(txValid), 32'd1);
        rst = 1'b1;
        txReady = 1'b1;
        #1;
        checkOutput("rstx_held_tx_valid", 32'(txValid), 32'd0);
        checkOutput("rstx_held_req_ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        reqValid = 4'b1000; reqData = 32'h73000000; reqLast = 4'b1000; txReady = 1'b1;
        #1;
        checkOutput("rstx_after_tx_valid", 32'(txValid), 32'd0);
        checkOutput("rstx_after_req_ready", 32'(reqReady), 32'd0);
        checkOutput("rstx_after_busy", 32'(busy), 32'd0);
        checkOutput("rstx_after_grant", 32'(grantId), 32'd0);
        applyStimulus(4'b1000, 32'h73000000, 4'b1000, 1'b1);
        checkOutput("rstx_req3_tx_valid", 32'(txValid), 32'd1);
        checkOutput("rstx_req3_tx_data", 32'(txData), 32'h73);
        checkOutput("rstx_req3_grant", 32'(grantId), 32'd3);
        checkOutput("rstx_req3_req_ready", 32'(reqReady), 32'b1000);

        // Zero-gap instance: back-to-back packets separated by one IDLE cycle.
        idx0 = 0; idx1 = 0; nAcc = 0; busyAt3 = -1;
        for (int i = 0; i < 4; i++) begin accCyc[i] = -1; accByte[i] = -1; end
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            bReqValid = '0;
            bReqLast  = '0;
            bReqValid[0] = (idx0 < 2);
            bReqValid[1] = (idx1 < 2);
            bReqLast[0]  = (idx0 == 1);
            bReqLast[1]  = (idx1 == 1);
            bReqData  = {16'h0000, 8'hC0 + 8'(idx1), 8'hB0 + 8'(idx0)};
            bTxReady  = 1'b1;
            #1;
            if (cyc == 3) busyAt3 = int'(bBusy);
            if (bTxValid && bTxReady) begin
                if (nAcc < 4) begin
                    accCyc[nAcc]  = cyc;
                    accByte[nAcc] = int'(bTxData);
                end
                nAcc++;
                if (bReqReady[0]) idx0++;
                if (bReqReady[1]) idx1++;
            end
        end
        checkOutput("nogap_accept_count", 32'(nAcc), 32'd4);
        checkOutput("nogap_busy_idle_cycle", 32'(busyAt3), 32'd0);
        checkOutput("nogap_cyc0", 32'(accCyc[0]), 32'd1);
        checkOutput("nogap_cyc1", 32'(accCyc[1]), 32'd2);
        checkOutput("nogap_cyc2", 32'(accCyc[2]), 32'd4);
        checkOutput("nogap_cyc3", 32'(accCyc[3]), 32'd5);
        checkOutput("nogap_byte0", 32'(accByte[0]), 32'hB0);
        checkOutput("nogap_byte1", 32'(accByte[1]), 32'hB1);
        checkOutput("nogap_byte2", 32'(accByte[2]), 32'hC0);
        checkOutput("nogap_byte3", 32'(accByte[3]), 32'hC1);
        checkOutput("nogap_timeout_err", 32'(bTimeoutErr), 32'd0);

        // Randomized packet traffic against a packet-level round-robin model.
        for (int iter = 0; iter < 3; iter++) begin
            for (int r = 0; r < 4; r++) begin
                pkN[r] = $urandom_range(0, 3);
                memCnt[r] = 0;
                memPos[r] = 0;
                for (int p = 0; p < pkN[r]; p++) begin
                    pkLen[r][p] = $urandom_range(1, 4);
                    for (int b = 0; b < pkLen[r][p]; b++) begin
                        memData[r][memCnt[r]] = {2'(r), 6'(memCnt[r] + 16 * iter)};
                        memCnt[r]++;
                    end
                end
            end

            expN = 0; ptr = 0; remaining = 0;
            for (int r = 0; r < 4; r++) begin
                nextPk[r] = 0;
                modelPos[r] = 0;
                remaining += pkN[r];
            end
            while (remaining > 0) begin
                win = -1;
                for (int i = 0; i < 4; i++) begin
                    if (win < 0 && nextPk[(ptr + i) % 4] < pkN[(ptr + i) % 4]) win = (ptr + i) % 4;
                end
                for (int b = 0; b < pkLen[win][nextPk[win]]; b++) begin
                    expData[expN] = memData[win][modelPos[win]];
                    expLast[expN] = (b == pkLen[win][nextPk[win]] - 1);
                    modelPos[win]++;
                    expN++;
                end
                nextPk[win]++;
                ptr = (win + 1) % 4;
                remaining--;
            end

            resetDut();
            seen = 0; lowRun = 0; lastEnd = -100; prevLast = 0;
            for (int cyc = 0; cyc < 3000 && seen < expN; cyc++) begin
                v = '0; l = '0; d = '0;
                for (int r = 0; r < 4; r++) begin
                    if (memPos[r] < memCnt[r]) begin
                        v[r] = 1'b1;
                        d[8*r +: 8] = memData[r][memPos[r]];
                        l[r] = (memPos[r] == memCnt[r] - 1);
                        for (int p = 0, s = 0; p < pkN[r]; p++) begin
                            s += pkLen[r][p];
                            if (memPos[r] == s - 1) l[r] = 1'b1;
                        end
                    end
                end
                rdy = (lowRun >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                lowRun = rdy ? 0 : lowRun + 1;
                applyStimulus(v, d, l, rdy);
                checkOutput("rnd_timeout_err", 32'(timeoutErr), 32'd0);
                if (!rdy) begin
                    checkOutput("rnd_ready_while_stalled", 32'(reqReady), 32'd0);
                end else if (txValid) begin
                    checkOutput("rnd_ready_onehot", 32'($countones(reqReady)), 32'd1);
                    checkOutput($sformatf("rnd%0d_byte%0d", iter, seen), 32'(txData), 32'(expData[seen]));
                    if (prevLast != 0) begin
                        checkOutput("rnd_gap_spacing", 32'(cyc - lastEnd >= GAP_A + 2), 32'd1);
                    end
                    prevLast = int'(expLast[seen]);
                    if (expLast[seen]) lastEnd = cyc;
                    for (int r = 0; r < 4; r++) begin
                        if (reqReady[r]) memPos[r]++;
                    end
                    seen++;
                end
            end
            checkOutput($sformatf("rnd%0d_all_bytes", iter), 32'(seen), 32'(expN));
            for (int c = 0; c < 8; c++) begin
                applyStimulus(4'b0000, 32'h0, 4'b0000, 1'b1);
                checkOutput("rnd_trailing_tx_valid", 32'(txValid), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
